// File: rtl/dijkstra_path_writer.sv
// dijkstra_path_writer
//   Once the Dijkstra engine has finished, this block walks the predecessor
//   table backwards from destination to source. It writes a length-prefixed
//   path record through a simple enable/ready write channel:
//     base+1+k : k-th node walking backward (k=0 is the destination)
//     base     : number of node words (0 on error), written last
//   A missing predecessor, an out-of-range index or a cycle (hop count
//   reaching MAX_NODES) ends the walk with error=1 and length 0.
//
// Ports
//   clock, reset             : clock and asynchronous active-high reset
//   start                    : begin a walk (accepted only in IDLE or DONE)
//   source, destination      : path endpoints, latched on accepted start
//   base_address             : record base, latched on accepted start
//   prev_vector              : flattened predecessor table, stable while busy
//   mem_write_enable/ready   : write handshake, transfer when both are high
//   mem_addr, mem_write_data : write address and zero-extended data
//   busy, done, error        : status; error and path_length valid while done
//   path_length              : node words written (0 on error)

`ifndef DEFAULT_MAX_NODES
`define DEFAULT_MAX_NODES 8
`endif
`ifndef DEFAULT_INDEX_WIDTH
`define DEFAULT_INDEX_WIDTH 4
`endif
`ifndef DEFAULT_MADDR_WIDTH
`define DEFAULT_MADDR_WIDTH 16
`endif
`ifndef DEFAULT_MDATA_WIDTH
`define DEFAULT_MDATA_WIDTH 16
`endif
`ifndef NO_PREVIOUS_NODE
`define NO_PREVIOUS_NODE '1
`endif

module dijkstra_path_writer #(
  parameter int MAX_NODES   = `DEFAULT_MAX_NODES,
  parameter int INDEX_WIDTH = `DEFAULT_INDEX_WIDTH,
  parameter int MADDR_WIDTH = `DEFAULT_MADDR_WIDTH,
  parameter int MDATA_WIDTH = `DEFAULT_MDATA_WIDTH
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             start,
  input  logic [INDEX_WIDTH-1:0]           source,
  input  logic [INDEX_WIDTH-1:0]           destination,
  input  logic [MADDR_WIDTH-1:0]           base_address,
  input  logic [MAX_NODES*INDEX_WIDTH-1:0] prev_vector,
  output logic                             mem_write_enable,
  input  logic                             mem_write_ready,
  output logic [MADDR_WIDTH-1:0]           mem_addr,
  output logic [MDATA_WIDTH-1:0]           mem_write_data,
  output logic                             busy,
  output logic                             done,
  output logic                             error,
  output logic [INDEX_WIDTH:0]             path_length
);

  localparam int CW = INDEX_WIDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE_NODE,
    S_GAP,
    S_WRITE_LEN,
    S_DONE
  } state_t;

  state_t                 r_state, w_state_next;
  logic [INDEX_WIDTH-1:0] r_source, w_source_next;
  logic [INDEX_WIDTH-1:0] r_node, w_node_next;
  logic [MADDR_WIDTH-1:0] r_base, w_base_next;
  logic [CW-1:0]          r_count, w_count_next;
  logic [CW-1:0]          r_len, w_len_next;
  logic                   r_to_len, w_to_len_next;  // next write after GAP is the length word
  logic                   r_busy, w_busy_next;
  logic                   r_done, w_done_next;
  logic                   r_error, w_error_next;
  logic [CW-1:0]          r_path_len, w_path_len_next;

  logic [CW-1:0]          w_count_inc;
  logic [INDEX_WIDTH-1:0] w_prev;
  logic                   w_prev_bad;
  logic [INDEX_WIDTH-1:0] w_prev_table [MAX_NODES];

  // Unflatten the predecessor table once so the lookup below is a plain mux.
  for (genvar gi = 0; gi < MAX_NODES; gi++) begin : g_prev
    assign w_prev_table[gi] = prev_vector[gi*INDEX_WIDTH +: INDEX_WIDTH];
  end

  // A current node outside the table (e.g. a bad destination) reads as
  // "no predecessor", which routes it into the error path.
  always_comb begin
    w_prev = `NO_PREVIOUS_NODE;
    for (int n = 0; n < MAX_NODES; n++) begin
      if (r_node == INDEX_WIDTH'(n)) w_prev = w_prev_table[n];
    end
  end

  assign w_count_inc = r_count + CW'(1);
  // Hitting MAX_NODES hops without reaching the source means a cycle.
  assign w_prev_bad  = (w_prev == `NO_PREVIOUS_NODE) ||
                       (32'(w_prev) >= MAX_NODES) ||
                       (32'(w_count_inc) == MAX_NODES);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_source   <= '0;
      r_node     <= '0;
      r_base     <= '0;
      r_count    <= '0;
      r_len      <= '0;
      r_to_len   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_path_len <= '0;
    end else begin
      r_state    <= w_state_next;
      r_source   <= w_source_next;
      r_node     <= w_node_next;
      r_base     <= w_base_next;
      r_count    <= w_count_next;
      r_len      <= w_len_next;
      r_to_len   <= w_to_len_next;
      r_busy     <= w_busy_next;
      r_done     <= w_done_next;
      r_error    <= w_error_next;
      r_path_len <= w_path_len_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_source_next   = r_source;
    w_node_next     = r_node;
    w_base_next     = r_base;
    w_count_next    = r_count;
    w_len_next      = r_len;
    w_to_len_next   = r_to_len;
    w_busy_next     = r_busy;
    w_done_next     = r_done;
    w_error_next    = r_error;
    w_path_len_next = r_path_len;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_source_next = source;
          w_node_next   = destination;
          w_base_next   = base_address;
          w_count_next  = '0;
          w_len_next    = '0;
          w_to_len_next = 1'b0;
          w_done_next   = 1'b0;
          w_error_next  = 1'b0;
          w_busy_next   = 1'b1;
          w_state_next  = S_WRITE_NODE;
        end
      end
      S_WRITE_NODE: begin
        if (mem_write_ready) begin
          w_count_next = w_count_inc;
          w_state_next = S_GAP;
          // Source check comes first so a one-node path never looks up prev.
          if (r_node == r_source) begin
            w_len_next    = w_count_inc;
            w_to_len_next = 1'b1;
          end else if (w_prev_bad) begin
            w_len_next    = '0;
            w_error_next  = 1'b1;
            w_to_len_next = 1'b1;
          end else begin
            w_node_next = w_prev;
          end
        end
      end
      S_GAP: begin
        w_state_next = r_to_len ? S_WRITE_LEN : S_WRITE_NODE;
      end
      S_WRITE_LEN: begin
        if (mem_write_ready) begin
          w_path_len_next = r_len;
          w_done_next     = 1'b1;
          w_busy_next     = 1'b0;
          w_state_next    = S_DONE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Write channel is decoded straight from state so it drops the instant
  // reset is asserted and stays stable while a request waits for ready.
  always_comb begin
    mem_write_enable = 1'b0;
    mem_addr         = '0;
    mem_write_data   = '0;
    case (r_state)
      S_WRITE_NODE: begin
        mem_write_enable = 1'b1;
        mem_addr         = r_base + MADDR_WIDTH'(r_count) + MADDR_WIDTH'(1);
        mem_write_data   = MDATA_WIDTH'(r_node);
      end
      S_WRITE_LEN: begin
        mem_write_enable = 1'b1;
        mem_addr         = r_base;
        mem_write_data   = MDATA_WIDTH'(r_len);
      end
      default: ;
    endcase
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign error       = r_error;
  assign path_length = r_path_len;

endmodule
